// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit; SB/SH via 2-cycle read-modify-write; optional LSU_MISALIGN_TRAP_EN
module load_store_unit #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] saved_addr_q, saved_addr_d;
    logic [2:0]  saved_funct3_q, saved_funct3_d;
    logic [15:0] saved_wdata_q, saved_wdata_d;
    logic [31:0] saved_word_q, saved_word_d;

    logic        funct_ok;
    logic        range_ok;
    logic        misalign;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        funct_ok = 1'b0;
        if (req_we) begin
            funct_ok = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
        end else begin
            funct_ok = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                       (funct3 == 3'd4) || (funct3 == 3'd5);
        end
        range_ok = ({2'b00, addr[31:2]} < DEPTH_W);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (((funct3 == 3'd1) || (funct3 == 3'd5)) && addr[0]) ||
                   ((funct3 == 3'd2) && (addr[1:0] != 2'b00));
`else
        // Misaligned low bits are simply dropped by lane selection below.
        misalign = 1'b0;
`endif
        req_err = !funct_ok || !range_ok || misalign;
    end

    always_comb begin
        byte_lane = 8'h00;
        unique case (addr[1:0])
            2'd0: byte_lane = mem_rd[7:0];
            2'd1: byte_lane = mem_rd[15:8];
            2'd2: byte_lane = mem_rd[23:16];
            2'd3: byte_lane = mem_rd[31:24];
        endcase
        half_lane = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        load_ext = 32'h0;
        case (funct3)
            3'd0:    load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'd1:    load_ext = {{16{half_lane[15]}}, half_lane};
            3'd2:    load_ext = mem_rd;
            3'd4:    load_ext = {24'h0, byte_lane};
            3'd5:    load_ext = {16'h0, half_lane};
            default: load_ext = 32'h0;
        endcase
    end

    always_comb begin
        merged = saved_word_q;
        if (saved_funct3_q == 3'd0) begin
            merged[{saved_addr_q[1:0], 3'b000} +: 8] = saved_wdata_q[7:0];
        end else if (saved_addr_q[1]) begin
            merged[31:16] = saved_wdata_q;
        end else begin
            merged[15:0] = saved_wdata_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        saved_addr_d   = saved_addr_q;
        saved_funct3_d = saved_funct3_q;
        saved_wdata_d  = saved_wdata_q;
        saved_word_d   = saved_word_q;
        rdata          = 32'h0;
        ready          = 1'b0;
        stall          = 1'b0;
        err            = 1'b0;
        mem_we         = 1'b0;
        mem_wd         = 32'h0;
        mem_a          = {addr[31:2], 2'b00};

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        err   = 1'b1;
                        ready = 1'b1;
                    end else if (!req_we) begin
                        ready = 1'b1;
                        rdata = load_ext;
                    end else if (funct3 == 3'd2) begin
                        mem_we = 1'b1;
                        mem_wd = wdata;
                        ready  = 1'b1;
                    end else begin
                        // Sub-word store: grab the current word, write the merged value next cycle.
                        stall          = 1'b1;
                        saved_addr_d   = addr;
                        saved_funct3_d = funct3;
                        saved_wdata_d  = wdata[15:0];
                        saved_word_d   = mem_rd;
                        state_d        = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_a   = {saved_addr_q[31:2], 2'b00};
                mem_we  = 1'b1;
                mem_wd  = merged;
                ready   = 1'b1;
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            rdata  = 32'h0;
            ready  = 1'b0;
            stall  = 1'b0;
            err    = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            saved_addr_q   <= 32'h0;
            saved_funct3_q <= 3'h0;
            saved_wdata_q  <= 16'h0;
            saved_word_q   <= 32'h0;
        end else begin
            state_q        <= state_d;
            saved_addr_q   <= saved_addr_d;
            saved_funct3_q <= saved_funct3_d;
            saved_wdata_q  <= saved_wdata_d;
            saved_word_q   <= saved_word_d;
        end
    end

endmodule
